// File: rtl/uart_pkg.sv
// Shared definitions for the UART transceiver: FSM state type, oversampling
// ratio, default clock/line rates and the divisor helpers derived from them.
package uart_pkg;

  // Both the transmit and receive FSMs walk the same four frame phases.
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_e;

  localparam int OVERSAMPLE = 16;
  localparam int DEF_CLK_HZ = 50000000;
  localparam int DEF_BAUD   = 115200;

  // Clocks per transmitted bit (truncated).
  function automatic int tx_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

  // Clocks per receive oversample tick (truncated).
  function automatic int rx_div(input int clk_hz, input int baud);
    return clk_hz / (OVERSAMPLE * baud);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running clock divider emitting a one-clock tick every DIV clocks.
// restart_i re-phases the divider so the next tick lands DIV clocks later.
module uart_baud_gen #(
  parameter int DIV = 434
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart_i,
  output logic tick_o
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  // Count up, wrapping at LAST or snapping back to zero on a restart.
  always_comb begin
    cnt_d = cnt_q + W'(1);
    if (restart_i || (cnt_q == LAST)) cnt_d = '0;
  end

  // Divider count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/uart_transceiver.sv
// Full-duplex 8N1 UART. Independent TX and RX paths; RX oversamples at 16x.
// Optional build macro UART_FRAME_ERR_EN adds sticky err / err_code outputs
// reporting framing errors (bit0) and overruns (bit1).
module uart_transceiver
  import uart_pkg::*;
#(
  parameter int CLK_HZ = DEF_CLK_HZ,
  parameter int BAUD   = DEF_BAUD
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] din,
  input  logic       wr_en,
  output logic       tx,
  output logic       tx_busy,
  input  logic       rx,
  output logic       rdy,
  input  logic       rdy_clr,
  output logic [7:0] dout
`ifdef UART_FRAME_ERR_EN
  ,
  output logic       err,
  output logic [1:0] err_code
`endif
);

  localparam int TX_DIV = tx_div(CLK_HZ, BAUD);
  localparam int RX_DIV = rx_div(CLK_HZ, BAUD);
  localparam logic [3:0] HALF_BIT = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] FULL_BIT = 4'(OVERSAMPLE - 1);

  // ---------------- transmitter ----------------
  uart_state_e tx_state_q, tx_state_d;
  logic [7:0]  tx_sh_q, tx_sh_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic        tx_q, tx_d;
  logic        tx_accept, tx_tick;

  assign tx_accept = wr_en && (tx_state_q == IDLE);

  // Bit timer re-phased on acceptance so the start bit lasts a full TX_DIV.
  uart_baud_gen #(.DIV(TX_DIV)) u_tx_baud (
    .clk       (clk),
    .rst_n     (rst_n),
    .restart_i (tx_accept),
    .tick_o    (tx_tick)
  );

  // TX next state: line level is registered alongside the frame phase.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_sh_d    = tx_sh_q;
    tx_bit_d   = tx_bit_q;
    tx_d       = tx_q;
    case (tx_state_q)
      IDLE: if (wr_en) begin
        tx_state_d = START;
        tx_sh_d    = din;
        tx_bit_d   = '0;
        tx_d       = 1'b0;
      end
      START: if (tx_tick) begin
        tx_state_d = DATA;
        tx_d       = tx_sh_q[0];
      end
      DATA: if (tx_tick) begin
        tx_sh_d  = {1'b0, tx_sh_q[7:1]};
        tx_bit_d = tx_bit_q + 3'd1;
        if (tx_bit_q == 3'd7) begin
          tx_state_d = STOP;
          tx_d       = 1'b1;
        end else begin
          tx_d = tx_sh_q[1];
        end
      end
      STOP: if (tx_tick) tx_state_d = IDLE;
      default: tx_state_d = IDLE;
    endcase
  end

  // TX state registers; reset forces the line back to idle high at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= IDLE;
      tx_sh_q    <= '0;
      tx_bit_q   <= '0;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_sh_q    <= tx_sh_d;
      tx_bit_q   <= tx_bit_d;
      tx_q       <= tx_d;
    end
  end

  assign tx      = tx_q;
  assign tx_busy = (tx_state_q != IDLE);

  // ---------------- receiver ----------------
  uart_state_e rx_state_q, rx_state_d;
  logic        rx_meta_q, rx_sync_q;
  logic [3:0]  rx_tcnt_q, rx_tcnt_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_sh_q, rx_sh_d;
  logic [7:0]  dout_q, dout_d;
  logic        rdy_q, rdy_d;
  logic        rx_tick, rx_done;
`ifdef UART_FRAME_ERR_EN
  logic        rx_ferr;
`endif

  // 16x oversample tick, free running.
  uart_baud_gen #(.DIV(RX_DIV)) u_rx_baud (
    .clk       (clk),
    .rst_n     (rst_n),
    .restart_i (1'b0),
    .tick_o    (rx_tick)
  );

  // Two-flop synchroniser for the asynchronous rx pin, idling high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  // RX next state: mid-bit sampling driven by the oversample tick count.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_tcnt_d  = rx_tcnt_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_done    = 1'b0;
`ifdef UART_FRAME_ERR_EN
    rx_ferr    = 1'b0;
`endif
    case (rx_state_q)
      IDLE: if (!rx_sync_q) begin
        rx_state_d = START;
        rx_tcnt_d  = '0;
      end
      START: if (rx_tick) begin
        rx_tcnt_d = rx_tcnt_q + 4'd1;
        if (rx_tcnt_q == HALF_BIT) begin
          rx_tcnt_d  = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_sync_q ? IDLE : DATA;
        end
      end
      DATA: if (rx_tick) begin
        rx_tcnt_d = rx_tcnt_q + 4'd1;
        if (rx_tcnt_q == FULL_BIT) begin
          rx_sh_d  = {rx_sync_q, rx_sh_q[7:1]};
          rx_bit_d = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = STOP;
        end
      end
      STOP: if (rx_tick) begin
        rx_tcnt_d = rx_tcnt_q + 4'd1;
        if (rx_tcnt_q == FULL_BIT) begin
          rx_state_d = IDLE;
          rx_done    = rx_sync_q;
`ifdef UART_FRAME_ERR_EN
          rx_ferr    = !rx_sync_q;
`endif
        end
      end
      default: rx_state_d = IDLE;
    endcase
  end

  // Host-facing result: a completing byte beats a same-cycle clear.
  always_comb begin
    dout_d = dout_q;
    rdy_d  = rdy_q;
    if (rdy_clr) rdy_d = 1'b0;
    if (rx_done) begin
      dout_d = rx_sh_q;
      rdy_d  = 1'b1;
    end
  end

  // RX state and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q <= IDLE;
      rx_tcnt_q  <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      dout_q     <= '0;
      rdy_q      <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_tcnt_q  <= rx_tcnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      dout_q     <= dout_d;
      rdy_q      <= rdy_d;
    end
  end

  assign dout = dout_q;
  assign rdy  = rdy_q;

`ifdef UART_FRAME_ERR_EN
  logic [1:0] code_q, code_d;
  logic       overrun;

  assign overrun = rx_done && rdy_q && !rdy_clr;

  // Sticky error causes, cleared with rdy; a new event beats the clear.
  always_comb begin
    code_d = code_q;
    if (rdy_clr) code_d = '0;
    if (rx_ferr) code_d[0] = 1'b1;
    if (overrun) code_d[1] = 1'b1;
  end

  // Error cause register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) code_q <= '0;
    else        code_q <= code_d;
  end

  assign err      = |code_q;
  assign err_code = code_q;
`endif

endmodule

// File: tb/tb_uart_transceiver.sv
// Self-checking bench for uart_transceiver: directed TX/RX frames, false
// starts, framing errors, an echo loop and randomized loopback traffic.
`timescale 1ns/1ps
module tb_uart_transceiver;

  localparam int TX_DIV = 50000000 / 115200;  // 434
  localparam int HALF   = TX_DIV / 2;         // 217

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b1;
  logic       wr_en   = 1'b0;
  logic       rdy_clr = 1'b0;
  logic       rx_drv  = 1'b1;
  logic       loop_en = 1'b0;
  logic [7:0] din     = 8'h00;
  logic       tx, tx_busy, rdy, rx;
  logic [7:0] dout;
`ifdef UART_FRAME_ERR_EN
  logic       err;
  logic [1:0] err_code;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model of the host-visible receive result.
  logic [7:0] exp_dout = 8'h00;
  logic       exp_rdy  = 1'b0;

  // Scratch variables (one set per concurrent branch).
  logic [7:0] b;
  logic       flag;
  int         rdy_at;
  int         rdy_at_h;
  int         echoed;
  logic [7:0] cap_b;
  logic       cap_ok;
  logic       cap_all_ok;
  logic [7:0] tx_seen[$];
  logic [7:0] echo_src[$];

  assign rx = loop_en ? tx : rx_drv;

  always #10 clk = ~clk;

  uart_transceiver dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .din      (din),
    .wr_en    (wr_en),
    .tx       (tx),
    .tx_busy  (tx_busy),
    .rx       (rx),
    .rdy      (rdy),
    .rdy_clr  (rdy_clr),
    .dout     (dout)
`ifdef UART_FRAME_ERR_EN
    ,
    .err      (err),
    .err_code (err_code)
`endif
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Line level of bit i (0 = start, 1..8 = data LSB first, 9 = stop) of a frame.
  function automatic logic frame_bit(input logic [7:0] v, input int i);
    if (i == 0) return 1'b0;
    if (i == 9) return 1'b1;
    return v[i-1];
  endfunction

  // Drive one frame on rx at the nominal bit time. A bad stop bit is held low
  // only for the first part of the bit so the line is idle before the next start
  // could be mis-detected. rdy_o reports the stop-bit cycle where rdy was seen.
  task automatic send_rx(input logic [7:0] v, input logic stop_ok, output int rdy_o);
    rdy_o = -1;
    for (int i = 0; i < 9; i++) begin
      rx_drv = frame_bit(v, i);
      step(TX_DIV);
    end
    for (int c = 0; c < TX_DIV; c++) begin
      rx_drv = (stop_ok || c >= 260) ? 1'b1 : 1'b0;
      step(1);
      if (rdy_o < 0 && rdy === 1'b1) rdy_o = c;
    end
    rx_drv = 1'b1;
  endtask

  // Decode one frame from tx by mid-bit sampling.
  task automatic capture_tx(output logic [7:0] v, output logic ok);
    int waited;
    waited = 0;
    v = 8'h00;
    ok = 1'b0;
    while (tx !== 1'b0 && waited < 12000) begin
      step(1);
      waited++;
    end
    if (tx !== 1'b0) return;
    step(HALF - 1);
    ok = (tx === 1'b0);
    for (int i = 1; i <= 9; i++) begin
      step(TX_DIV);
      if (i < 9) v[i-1] = tx;
      else ok = ok && (tx === 1'b1);
    end
  endtask

  task automatic clear_rdy(input string tag);
    rdy_clr = 1'b1;
    step(1);
    rdy_clr = 1'b0;
    exp_rdy = 1'b0;
    chk(tag, 32'(rdy), 32'(exp_rdy));
  endtask

  // Receive one good frame and check latency, flag and data.
  task automatic rx_good(input string tag, input logic [7:0] v);
    send_rx(v, 1'b1, rdy_at);
    exp_dout = v;
    exp_rdy  = 1'b1;
    chk({tag, "_lat"}, 32'(rdy_at >= 1 && rdy_at <= HALF + 27 + 4), 32'd1);
    chk({tag, "_rdy"}, 32'(rdy), 32'(exp_rdy));
    chk({tag, "_dout"}, 32'(dout), 32'(exp_dout));
  endtask

  initial begin
    // ---- reset ----
    #1 rst_n = 1'b0;
    step(10);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(tx_busy), 32'd0);
    chk("rst_rdy", 32'(rdy), 32'd0);
    chk("rst_dout", 32'(dout), 32'h00);
    rst_n = 1'b1;
    flag = 1'b1;
    for (int c = 0; c < 5000; c++) begin
      step(1);
      if (tx !== 1'b1 || tx_busy !== 1'b0 || rdy !== 1'b0) flag = 1'b0;
    end
    chk("idle_quiet", 32'(flag), 32'd1);

    // ---- transmit 8'hA5, with an ignored write mid-frame ----
    din = 8'hA5; wr_en = 1'b1;
    step(1);
    wr_en = 1'b0; din = 8'h00;
    chk("tx_start_low", 32'(tx), 32'd0);
    chk("tx_busy_rise", 32'(tx_busy), 32'd1);
    step(HALF - 1);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("tx_a5_bit%0d", i), 32'(tx), 32'(frame_bit(8'hA5, i)));
      if (i == 2) begin
        din = 8'hFF; wr_en = 1'b1;
        step(1);
        wr_en = 1'b0;
        chk("wr_ignored_busy", 32'(tx_busy), 32'd1);
        step(TX_DIV - 1);
      end else if (i < 9) begin
        step(TX_DIV);
      end
    end
    step(TX_DIV - HALF);
    chk("busy_hold_4339", 32'(tx_busy), 32'd1);
    step(1);
    chk("busy_fall_4340", 32'(tx_busy), 32'd0);
    chk("tx_idle_after", 32'(tx), 32'd1);
    step(5);
    chk("no_queued_frame", 32'(tx_busy), 32'd0);

    // ---- reset mid-frame aborts immediately ----
    din = 8'h3C; wr_en = 1'b1;
    step(1);
    wr_en = 1'b0;
    step(1000);
    chk("tx_pre_rst", 32'(tx), 32'(frame_bit(8'h3C, 2)));
    rst_n = 1'b0;
    #2;
    chk("tx_async_rst", 32'(tx), 32'd1);
    chk("busy_async_rst", 32'(tx_busy), 32'd0);
    step(10);
    rst_n = 1'b1;
    step(5);
    chk("tx_after_rst", 32'(tx), 32'd1);

    // ---- receive 8'h33 and clear ----
    rx_good("rx_33", 8'h33);
    clear_rdy("rdy_clr_33");

    // ---- false start glitch, then a good frame to prove RX recovered ----
    rx_drv = 1'b0;
    step(100);
    rx_drv = 1'b1;
    step(600);
    chk("glitch_rdy", 32'(rdy), 32'(exp_rdy));
    chk("glitch_dout", 32'(dout), 32'(exp_dout));
    rx_good("rx_after_glitch", 8'hC3);
    clear_rdy("rdy_clr_c3");

    // ---- framing error: byte discarded ----
    send_rx(8'h5C, 1'b0, rdy_at);
    step(600);
    chk("ferr_rdy", 32'(rdy), 32'(exp_rdy));
    chk("ferr_dout", 32'(dout), 32'(exp_dout));
`ifdef UART_FRAME_ERR_EN
    chk("ferr_err", 32'(err), 32'd1);
    chk("ferr_code", 32'(err_code), 32'd1);
    clear_rdy("rdy_clr_ferr");
    chk("ferr_err_clr", 32'(err), 32'd0);
`endif

    // ---- echo loop: "1","2","A" back-to-back ----
    echo_src = '{8'h31, 8'h32, 8'h41};
    tx_seen.delete();
    cap_all_ok = 1'b1;
    echoed = 0;
    fork
      begin : host_side
        for (int k = 0; k < 3; k++) send_rx(echo_src[k], 1'b1, rdy_at_h);
      end
      begin : responder
        for (int c = 0; c < 20000 && echoed < 3; c++) begin
          if (rdy === 1'b1 && tx_busy === 1'b0) begin
            din = dout; wr_en = 1'b1; rdy_clr = 1'b1;
            step(1);
            wr_en = 1'b0; rdy_clr = 1'b0;
            echoed++;
          end else begin
            step(1);
          end
        end
      end
      begin : tx_capture
        for (int k = 0; k < 3; k++) begin
          capture_tx(cap_b, cap_ok);
          tx_seen.push_back(cap_b);
          if (!cap_ok) cap_all_ok = 1'b0;
        end
      end
    join
    exp_rdy = 1'b0;
    chk("echo_count", 32'(echoed), 32'd3);
    chk("echo_framing", 32'(cap_all_ok), 32'd1);
    for (int k = 0; k < 3; k++)
      chk($sformatf("echo_byte%0d", k), 32'(tx_seen[k]), 32'(echo_src[k]));
    step(500);
    chk("echo_rdy_cleared", 32'(rdy), 32'(exp_rdy));

    // ---- random received bytes ----
    for (int k = 0; k < 2; k++) begin
      b = 8'($urandom);
      rx_good($sformatf("rx_rand%0d", k), b);
      clear_rdy($sformatf("rdy_clr_rand%0d", k));
    end

    // ---- overrun: second byte overwrites, rdy stays set ----
    b = 8'($urandom);
    rx_good("ovr_first", b);
    b = ~b;
    send_rx(b, 1'b1, rdy_at);
    exp_dout = b;
    chk("ovr_rdy", 32'(rdy), 32'(exp_rdy));
    chk("ovr_dout", 32'(dout), 32'(exp_dout));
`ifdef UART_FRAME_ERR_EN
    chk("ovr_code", 32'(err_code), 32'd2);
`endif
    clear_rdy("rdy_clr_ovr");

    // ---- random loopback tx -> rx ----
    loop_en = 1'b1;
    for (int k = 0; k < 2; k++) begin
      b = 8'($urandom);
      din = b; wr_en = 1'b1;
      step(1);
      wr_en = 1'b0;
      flag = 1'b0;
      for (int c = 0; c < 5000 && !flag; c++) begin
        step(1);
        if (rdy === 1'b1) flag = 1'b1;
      end
      exp_dout = b;
      exp_rdy  = 1'b1;
      chk($sformatf("loop%0d_rdy", k), 32'(flag), 32'(exp_rdy));
      chk($sformatf("loop%0d_dout", k), 32'(dout), 32'(exp_dout));
      step(400);
      clear_rdy($sformatf("loop%0d_clr", k));
    end
    loop_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
